// File: rtl/butterfly16_collect.sv
// Stage-1 butterfly of the 16-point row DCT: gathers one row of 16 samples over a
// valid/ready stream and presents even sums a_k and odd differences b_k as one word.
module butterfly16_collect #(
    parameter int IN_WIDTH = 9,
    parameter int WIDTH    = 20
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_WIDTH-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    a0,
    output logic [WIDTH-1:0]    a1,
    output logic [WIDTH-1:0]    a2,
    output logic [WIDTH-1:0]    a3,
    output logic [WIDTH-1:0]    a4,
    output logic [WIDTH-1:0]    a5,
    output logic [WIDTH-1:0]    a6,
    output logic [WIDTH-1:0]    a7,
    output logic [WIDTH-1:0]    b0,
    output logic [WIDTH-1:0]    b1,
    output logic [WIDTH-1:0]    b2,
    output logic [WIDTH-1:0]    b3,
    output logic [WIDTH-1:0]    b4,
    output logic [WIDTH-1:0]    b5,
    output logic [WIDTH-1:0]    b6,
    output logic [WIDTH-1:0]    b7,
    output logic [3:0]          out_row
);

    if (WIDTH < IN_WIDTH + 1) begin : g_width_check
        $error("butterfly16_collect: WIDTH must be at least IN_WIDTH+1");
    end

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_FULL    = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [3:0]              row_cnt_q, row_cnt_d;
    logic [3:0]              out_row_q, out_row_d;
    logic                    out_valid_q, out_valid_d;
    logic [IN_WIDTH-1:0]     samp_q [16];
    logic [IN_WIDTH-1:0]     samp_d [16];
    logic signed [WIDTH-1:0] a_q [8];
    logic signed [WIDTH-1:0] a_d [8];
    logic signed [WIDTH-1:0] b_q [8];
    logic signed [WIDTH-1:0] b_d [8];
    logic signed [WIDTH-1:0] sum_s [8];
    logic signed [WIDTH-1:0] dif_s [8];
    logic                    accept_s;
    logic                    xfer_s;

    function automatic logic signed [WIDTH-1:0] sext(input logic [IN_WIDTH-1:0] x);
        return {{(WIDTH-IN_WIDTH){x[IN_WIDTH-1]}}, x};
    endfunction

    assign in_ready = (state_q == ST_COLLECT) && !flush;
    assign accept_s = in_valid && in_ready;
    // A full row moves to the output slot when it is empty or being consumed this edge.
    assign xfer_s   = (state_q == ST_FULL) && !flush && (!out_valid_q || out_ready);

    // Butterfly over the collected row at full output width.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            sum_s[k] = sext(samp_q[k]) + sext(samp_q[15-k]);
            dif_s[k] = sext(samp_q[k]) - sext(samp_q[15-k]);
        end
    end

    // Next-state logic: flush beats accept and transfer; the output word only hands off.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        row_cnt_d   = row_cnt_q;
        samp_d      = samp_q;
        a_d         = a_q;
        b_d         = b_q;
        out_row_d   = out_row_q;
        out_valid_d = out_valid_q && !out_ready;
        if (flush) begin
            cnt_d     = 4'd0;
            row_cnt_d = 4'd0;
            state_d   = ST_COLLECT;
        end else if (accept_s) begin
            samp_d[cnt_q] = in_data;
            cnt_d         = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
                state_d = ST_FULL;
            end else begin
                state_d = ST_COLLECT;
            end
        end else if (xfer_s) begin
            a_d         = sum_s;
            b_d         = dif_s;
            out_row_d   = row_cnt_q;
            row_cnt_d   = row_cnt_q + 4'd1;
            out_valid_d = 1'b1;
            state_d     = ST_COLLECT;
        end else begin
            state_d = state_q;
        end
    end

    // State, collection buffer and output word registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= ST_COLLECT;
            cnt_q       <= 4'd0;
            row_cnt_q   <= 4'd0;
            out_row_q   <= 4'd0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                samp_q[i] <= {IN_WIDTH{1'b0}};
            end
            for (int i = 0; i < 8; i++) begin
                a_q[i] <= {WIDTH{1'b0}};
                b_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            row_cnt_q   <= row_cnt_d;
            out_row_q   <= out_row_d;
            out_valid_q <= out_valid_d;
            samp_q      <= samp_d;
            a_q         <= a_d;
            b_q         <= b_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_row   = out_row_q;
    assign a0 = a_q[0];
    assign a1 = a_q[1];
    assign a2 = a_q[2];
    assign a3 = a_q[3];
    assign a4 = a_q[4];
    assign a5 = a_q[5];
    assign a6 = a_q[6];
    assign a7 = a_q[7];
    assign b0 = b_q[0];
    assign b1 = b_q[1];
    assign b2 = b_q[2];
    assign b3 = b_q[3];
    assign b4 = b_q[4];
    assign b5 = b_q[5];
    assign b6 = b_q[6];
    assign b7 = b_q[7];

endmodule
